alu_issue_stage: RTL
====================

# alu_issue_stage

Registered ID→EX issue stage that drives the ALU's operand and 3-bit control inputs. Decodes RV32 opcode/funct3/funct7 into the ALU control code, selects the second operand (rs2 or immediate), and holds the result in a single-entry pipeline register with valid/ready handshake, stall and flush. Sits between instruction decode / register file read and the execute-stage ALU.

## Interface
- DATA_W, 32, operand width
- CNT_W, 8, width of illegal-instruction counter
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  decode stage presents an instruction
- ready_o  out  1  stage can accept this cycle
- opcode_i  in  7  instr[6:0]
- funct3_i  in  3  instr[14:12]
- funct7_i  in  7  instr[31:25]
- rs1_data_i  in  DATA_W  register-file read 1
- rs2_data_i  in  DATA_W  register-file read 2
- imm_i  in  DATA_W  sign-extended immediate from decode
- rd_addr_i  in  5  destination register
- flush_i  in  1  kill held and incoming instruction
- valid_o  out  1  EX-side instruction valid
- ready_i  in  1  EX stage consumes this cycle
- alu_ctrl_o  out  3  ALU control code
- data1_o  out  DATA_W  ALU operand 1
- data2_o  out  DATA_W  ALU operand 2
- rd_addr_o  out  5  destination register
- reg_write_o  out  1  result is written back
- illegal_o  out  1  held instruction was undecodable
- illegal_cnt_o  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- ALU codes: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, SRAI 111; 110 never emitted.
- Decode (opcode, funct7, funct3 → code, operand 2, reg_write):
  - 0110011: 0000000/111 AND; 0000000/100 XOR; 0000000/001 SLL; 0000000/000 ADD; 0100000/000 SUB; 0000001/000 MUL; operand 2 = rs2, reg_write 1.
  - 0010011: funct3 000 ADD (addi); funct3 101 with funct7 0100000 SRAI; operand 2 = imm, reg_write 1.
  - 0000011 (load): ADD, imm, reg_write 1. 0100011 (store): ADD, imm, reg_write 0.
  - 1100011 (branch): SUB, rs2, reg_write 0.
  - Anything else: illegal = 1, code ADD, operand 2 = rs2, reg_write 0.
- data1_o always captures rs1_data_i.
- ready_o = !valid_o || ready_i (combinational, no dependence on valid_i).
- Load: valid_i && ready_o && !flush_i → register all fields, valid_o ← 1.
- Drain: ready_i && valid_o without load → valid_o ← 0; data fields hold.
- Flush: valid_o ← 0 next cycle; overrides simultaneous load; counter not incremented.
- Hold: valid_o && !ready_i → all outputs stable.
- illegal_cnt_o increments by 1 on each load with illegal = 1; saturates at 2^CNT_W−1.

## Timing
- Latency 1 cycle from accepted valid_i to valid_o; throughput 1/cycle when ready_i held high.
- Reset (async assert, sync-to-clock release): valid_o 0, alu_ctrl_o 000, data1_o/data2_o 0, rd_addr_o 0, reg_write_o 0, illegal_o 0, illegal_cnt_o 0.
- Reset mid-transfer discards the held instruction; no output glitches to nonzero during reset.
- Simultaneous drain and load (full, ready_i=1, valid_i=1): new instruction replaces old in same edge, valid_o stays 1.
- Data fields are don't-care when valid_o = 0 but must not change except on load or reset.

## Structure
- Package alu_pkg: ALU code localparams (AND…SRAI), opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH), funct7 constants (F7_BASE, F7_ALT, F7_MULDIV).
- Sub-module alu_ctrl_dec: purely combinational decode (opcode/funct3/funct7 → code, sel_imm, reg_write, illegal); top holds register, handshake and counter.

## Test plan
- Reset: hold rst_i low with valid_i=1 → all outputs 0, ready_o=1; release → first load appears one cycle later.
- R-type sweep: sub (0110011, 0100000, 000), rs1=10, rs2=3 → alu_ctrl_o 100, data1_o 10, data2_o 3, reg_write_o 1; mul (0000001) → 101.
- I-type: srai (0010011, 0100000, 101), imm=5 → alu_ctrl_o 111, data2_o 5; store (0100011), imm=−4 → 011, data2_o 32'hFFFFFFFC, reg_write_o 0.
- Backpressure: load A, ready_i=0 for 3 cycles with B presented → ready_o=0, outputs hold A; ready_i=1 → B registered next edge, valid_o stays 1.
- Flush: flush_i=1 with valid_i=1 and valid_o=1 → valid_o 0 next cycle, illegal_cnt_o unchanged.
- Illegal: opcode 1111111 accepted 257 times with CNT_W=8 → illegal_o 1, reg_write_o 0, illegal_cnt_o saturates at 255.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU issue stage shared definitions:
// ALU control codes, opcodes and funct7 values.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32 decode into ALU code,
// operand-2 select, writeback and illegal flag.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] code,
  output logic       sel_imm,
  output logic       reg_write,
  output logic       illegal
);

  logic is_r, is_i, f7_b, f7_a, f7_m;

  assign is_r = (opcode == OP_R);
  assign is_i = (opcode == OP_I);
  assign f7_b = (funct7 == F7_BASE);
  assign f7_a = (funct7 == F7_ALT);
  assign f7_m = (funct7 == F7_MULDIV);

  always_comb begin
    code      = ALU_ADD;
    sel_imm   = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    unique case (1'b1)
      is_r && f7_b && funct3 == 3'b111: begin
        code = ALU_AND; reg_write = 1'b1;
      end
      is_r && f7_b && funct3 == 3'b100: begin
        code = ALU_XOR; reg_write = 1'b1;
      end
      is_r && f7_b && funct3 == 3'b001: begin
        code = ALU_SLL; reg_write = 1'b1;
      end
      is_r && f7_b && funct3 == 3'b000: begin
        code = ALU_ADD; reg_write = 1'b1;
      end
      is_r && f7_a && funct3 == 3'b000: begin
        code = ALU_SUB; reg_write = 1'b1;
      end
      is_r && f7_m && funct3 == 3'b000: begin
        code = ALU_MUL; reg_write = 1'b1;
      end
      is_i && funct3 == 3'b000: begin
        code = ALU_ADD; sel_imm = 1'b1;
        reg_write = 1'b1;
      end
      is_i && f7_a && funct3 == 3'b101: begin
        code = ALU_SRAI; sel_imm = 1'b1;
        reg_write = 1'b1;
      end
      opcode == OP_LOAD: begin
        code = ALU_ADD; sel_imm = 1'b1;
        reg_write = 1'b1;
      end
      opcode == OP_STORE: begin
        code = ALU_ADD; sel_imm = 1'b1;
      end
      opcode == OP_BRANCH: begin
        code = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ID->EX issue stage: decode, operand
// select, single-entry handshake register, illegal count.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [2:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [4:0]        rd_addr_o,
  output logic              reg_write_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  logic [2:0] dec_code;
  logic       dec_imm;
  logic       dec_wr;
  logic       dec_ill;
  logic       load;

  alu_ctrl_dec u_dec (
    .opcode    (opcode_i),
    .funct3    (funct3_i),
    .funct7    (funct7_i),
    .code      (dec_code),
    .sel_imm   (dec_imm),
    .reg_write (dec_wr),
    .illegal   (dec_ill)
  );

  assign ready_o = !valid_o || ready_i;
  assign load    = valid_i && ready_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      valid_o <= 1'b0;
    else if (flush_i)
      valid_o <= 1'b0;
    else if (load)
      valid_o <= 1'b1;
    else if (ready_i)
      valid_o <= 1'b0;
  end

  // Data fields only move on load so EX sees stable operands.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_ctrl_o  <= 3'b000;
      data1_o     <= '0;
      data2_o     <= '0;
      rd_addr_o   <= '0;
      reg_write_o <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (load) begin
      alu_ctrl_o  <= dec_code;
      data1_o     <= rs1_data_i;
      data2_o     <= dec_imm ? imm_i : rs2_data_i;
      rd_addr_o   <= rd_addr_i;
      reg_write_o <= dec_wr;
      illegal_o   <= dec_ill;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      illegal_cnt_o <= '0;
    else if (load && dec_ill && illegal_cnt_o != '1)
      illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
  end

endmodule
